// File: rtl/fp_pkg.sv
// Shared fp32 definitions for the iterative multiplier and divider.
// Field layout, exponent bias and the multiplier FSM encoding live here.
package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 24;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } fpmul_state_t;

endpackage

// File: rtl/mant_shift_add_mul.sv
// Iterative 24x24 shift-add mantissa multiplier retiring BITS_PER_CYCLE
// multiplier bits per clock; done flags the cycle whose edge writes the final product.
module mant_shift_add_mul
  import fp_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  output logic        busy,
  output logic        done,
  output logic [47:0] p
);

  localparam int STEPS = MANT_W / BITS_PER_CYCLE;

  logic [47:0] mc;
  logic [47:0] acc;
  logic [47:0] acc_next;
  logic [23:0] mb_sr;
  logic [4:0]  cnt;

  // mc carries the multiplicand pre-shifted to the weight of mb_sr[0]
  always_comb begin
    acc_next = acc;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mb_sr[j]) begin
        acc_next = acc_next + (mc << j);
      end
    end
  end

  assign done = busy && (cnt == 5'(STEPS - 1));
  assign p    = acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mc    <= '0;
      acc   <= '0;
      mb_sr <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mc    <= {24'b0, ma};
      acc   <= '0;
      mb_sr <= mb;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc   <= acc_next;
      mc    <= mc << BITS_PER_CYCLE;
      mb_sr <= mb_sr >> BITS_PER_CYCLE;
      cnt   <= cnt + 5'd1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_seq_mul.sv
// Iterative fp32 multiplier with valid/ready on both sides; one operation in flight.
// Denormal inputs multiply as signed zero; inf/NaN get no special treatment.
module fp_seq_mul
  import fp_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int EXP_BIAS       = 127
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf
);

  fpmul_state_t state;
  fp32_t        a_fp;
  fp32_t        b_fp;
  logic         sign_q;
  logic [7:0]   ea_q;
  logic [7:0]   eb_q;
  logic         accept;
  logic         zero_op;
  logic         core_busy;
  logic         core_done;
  logic [47:0]  core_p;
  logic [22:0]  unused_bits;

  logic signed [9:0] esum;
  logic [22:0]       frac;
  logic              guard;
  logic [23:0]       frac_rnd;
  logic [31:0]       norm_result;
  logic              norm_ovf;
  logic              norm_unf;

  assign a_fp      = a;
  assign b_fp      = b;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign zero_op   = (a_fp.exp == 8'd0) || (b_fp.exp == 8'd0);

  // Product bits below the guard position never influence rounding
  assign unused_bits = {core_busy, core_p[21:0]};

  mant_shift_add_mul #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_core (
    .clk  (clk),
    .rstn (rstn),
    .start(accept && !zero_op),
    .ma   ({1'b1, a_fp.frac}),
    .mb   ({1'b1, b_fp.frac}),
    .busy (core_busy),
    .done (core_done),
    .p    (core_p)
  );

  // Normalise the 48b product, round to nearest with ties away, then range-check
  always_comb begin
    esum = 10'({2'b00, ea_q}) + 10'({2'b00, eb_q}) - 10'(EXP_BIAS);
    if (core_p[47]) begin
      frac  = core_p[46:24];
      guard = core_p[23];
      esum  = esum + 10'sd1;
    end else begin
      frac  = core_p[45:23];
      guard = core_p[22];
    end
    frac_rnd = {1'b0, frac} + {23'b0, guard};
    if (frac_rnd[23]) begin
      esum = esum + 10'sd1;
    end
    norm_ovf    = 1'b0;
    norm_unf    = 1'b0;
    norm_result = {sign_q, esum[7:0], frac_rnd[22:0]};
    if (esum >= 10'sd255) begin
      norm_result = {sign_q, 8'hFF, 23'b0};
      norm_ovf    = 1'b1;
    end else if (esum <= 10'sd0) begin
      norm_result = {sign_q, 31'b0};
      norm_unf    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      sign_q <= 1'b0;
      ea_q   <= '0;
      eb_q   <= '0;
      result <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q <= a_fp.sign ^ b_fp.sign;
            ea_q   <= a_fp.exp;
            eb_q   <= b_fp.exp;
            if (zero_op) begin
              result <= {a_fp.sign ^ b_fp.sign, 31'b0};
              ovf    <= 1'b0;
              unf    <= 1'b0;
              state  <= DONE;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          if (core_done) begin
            state <= NORM;
          end
        end
        NORM: begin
          result <= norm_result;
          ovf    <= norm_ovf;
          unf    <= norm_unf;
          state  <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            ovf   <= 1'b0;
            unf   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
